// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   localparam logic [3:0] FUN_DIV = 4'b0011;
   localparam logic [3:0] FUN_NOP = 4'b1000;

   // Result-bus selection, taken from FUN[3:2]
   localparam logic [1:0] GRP_ARITH = 2'b00;
   localparam logic [1:0] GRP_LOGIC = 2'b01;
   localparam logic [1:0] GRP_CMP   = 2'b10;
   localparam logic [1:0] GRP_SHIFT = 2'b11;

   // A divide whose divisor is zero is answered locally and never reaches the ALU
   function automatic logic is_div_by_zero(input logic [3:0] fun, input logic b_is_zero);
      return (fun == FUN_DIV) && b_is_zero;
   endfunction

endpackage

// File: rtl/alu_rr_arbiter2.sv
// Two-input round-robin grant; the priority pointer moves on an update pulse.
module alu_rr_arbiter2
   import alu_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       last_id,
   output logic [1:0] grant,
   output logic       grant_id
);

   // prio names the port that wins a tie; after serving a port the other one gets it
   logic prio;

   // Priority pointer register
   always_ff @(posedge clk) begin
      if (rst) begin
         prio <= 1'b0;
      end else if (update) begin
         prio <= ~last_id;
      end
   end

   // Grant: a lone requester wins outright, a tie goes to the priority port
   always_comb begin
      grant    = '0;
      grant_id = 1'b0;
      if (req == 2'b11) begin
         grant_id = prio;
      end else begin
         grant_id = req[1];
      end
      if (req != 2'b00) begin
         grant = 2'b01 << grant_id;
      end
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between two requesters, one operation in flight.
module alu_req_arbiter
   import alu_arb_pkg::*;
#(
   parameter int OP_WIDTH = 16,
   parameter int ALU_LAT  = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ0_VALID,
   output logic                  REQ0_READY,
   input  logic [OP_WIDTH-1:0]   REQ0_A,
   input  logic [OP_WIDTH-1:0]   REQ0_B,
   input  logic [3:0]            REQ0_FUN,
   input  logic                  REQ1_VALID,
   output logic                  REQ1_READY,
   input  logic [OP_WIDTH-1:0]   REQ1_A,
   input  logic [OP_WIDTH-1:0]   REQ1_B,
   input  logic [3:0]            REQ1_FUN,
   output logic                  RSP_VALID,
   input  logic                  RSP_READY,
   output logic                  RSP_ID,
   output logic [2*OP_WIDTH-1:0] RSP_DATA,
   output logic [3:0]            RSP_FLAGS,
   output logic                  RSP_ERR,
   output logic [OP_WIDTH-1:0]   ALU_A,
   output logic [OP_WIDTH-1:0]   ALU_B,
   output logic [3:0]            ALU_FUN,
   input  logic [2*OP_WIDTH-1:0] ALU_ARITH_OUT,
   input  logic [OP_WIDTH-1:0]   ALU_LOGIC_OUT,
   input  logic [OP_WIDTH-1:0]   ALU_CMP_OUT,
   input  logic [OP_WIDTH-1:0]   ALU_SHIFT_OUT,
   input  logic [3:0]            ALU_FLAGS
);

   // Operands reach the ALU on the edge leaving ISSUE and its outputs settle ALU_LAT
   // edges later; loading ALU_LAT lets the capture edge land one cycle after that.
   localparam logic [2:0] WAIT_LOAD = 3'(ALU_LAT);

   arb_state_t             state, state_nxt;
   logic [1:0]             grant;
   logic                   grant_id;
   logic                   accept;
   logic                   rsp_done;
   logic                   div_err;
   logic [OP_WIDTH-1:0]    cmd_a, cmd_b;
   logic [3:0]             cmd_fun;
   logic                   cmd_id;
   logic [2:0]             cnt;
   logic [2*OP_WIDTH-1:0]  cap_data;

   alu_rr_arbiter2 u_rr (
      .clk      (CLK),
      .rst      (RST),
      .req      ({REQ1_VALID, REQ0_VALID}),
      .update   (rsp_done),
      .last_id  (cmd_id),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign div_err   = is_div_by_zero(cmd_fun, cmd_b == '0);
   assign RSP_VALID = (state == RESP);

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, requester handshakes and response completion
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      rsp_done   = 1'b0;
      REQ0_READY = 1'b0;
      REQ1_READY = 1'b0;
      case (state)
         IDLE: begin
            if (!RST && (grant != 2'b00)) begin
               REQ0_READY = grant[0];
               REQ1_READY = grant[1];
               accept     = 1'b1;
               state_nxt  = ISSUE;
            end
         end
         ISSUE:   state_nxt = div_err ? RESP : WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         RESP: begin
            if (RSP_READY) begin
               rsp_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result bus selection; non-arithmetic buses are zero-extended
   always_comb begin
      cap_data = '0;
      case (cmd_fun[3:2])
         GRP_ARITH: cap_data = ALU_ARITH_OUT;
         GRP_LOGIC: cap_data = {{OP_WIDTH{1'b0}}, ALU_LOGIC_OUT};
         GRP_CMP:   cap_data = {{OP_WIDTH{1'b0}}, ALU_CMP_OUT};
         GRP_SHIFT: cap_data = {{OP_WIDTH{1'b0}}, ALU_SHIFT_OUT};
         default:   cap_data = '0;
      endcase
   end

   // Command latch, ALU drive, latency counter and response capture
   always_ff @(posedge CLK) begin
      if (RST) begin
         cmd_a     <= '0;
         cmd_b     <= '0;
         cmd_fun   <= FUN_NOP;
         cmd_id    <= 1'b0;
         cnt       <= '0;
         ALU_A     <= '0;
         ALU_B     <= '0;
         ALU_FUN   <= FUN_NOP;
         RSP_ID    <= 1'b0;
         RSP_DATA  <= '0;
         RSP_FLAGS <= '0;
         RSP_ERR   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cmd_a   <= grant_id ? REQ1_A   : REQ0_A;
                  cmd_b   <= grant_id ? REQ1_B   : REQ0_B;
                  cmd_fun <= grant_id ? REQ1_FUN : REQ0_FUN;
                  cmd_id  <= grant_id;
               end
            end
            ISSUE: begin
               if (div_err) begin
                  RSP_ID    <= cmd_id;
                  RSP_DATA  <= '0;
                  RSP_FLAGS <= '0;
                  RSP_ERR   <= 1'b1;
               end else begin
                  ALU_A   <= cmd_a;
                  ALU_B   <= cmd_b;
                  ALU_FUN <= cmd_fun;
                  cnt     <= WAIT_LOAD;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  RSP_ID    <= cmd_id;
                  RSP_DATA  <= cap_data;
                  RSP_FLAGS <= ALU_FLAGS;
                  RSP_ERR   <= 1'b0;
               end
            end
            RESP: begin
               if (RSP_READY) begin
                  ALU_FUN <= FUN_NOP;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter with a behavioural ALU_TOP stand-in.
module tb_alu_req_arbiter;

   typedef struct packed {
      logic [31:0] ar;
      logic [15:0] lg;
      logic [15:0] cm;
      logic [15:0] sh;
      logic [3:0]  fl;
   } alu_res_t;

   typedef struct packed {
      logic        id;
      logic [31:0] data;
      logic [3:0]  fl;
      logic        err;
   } exp_t;

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---- DUT with ALU_LAT = 1 ----
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [15:0] req_a   [2];
   logic [15:0] req_b   [2];
   logic [3:0]  req_fun [2];
   logic        rsp_valid, rsp_id, rsp_err;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_flags;
   logic [15:0] alu_a, alu_b;
   logic [3:0]  alu_fun;
   alu_res_t    p1;

   alu_req_arbiter #(.OP_WIDTH(16), .ALU_LAT(1)) dut (
      .CLK(clk), .RST(rst),
      .REQ0_VALID(req_valid[0]), .REQ0_READY(req_ready[0]),
      .REQ0_A(req_a[0]), .REQ0_B(req_b[0]), .REQ0_FUN(req_fun[0]),
      .REQ1_VALID(req_valid[1]), .REQ1_READY(req_ready[1]),
      .REQ1_A(req_a[1]), .REQ1_B(req_b[1]), .REQ1_FUN(req_fun[1]),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id),
      .RSP_DATA(rsp_data), .RSP_FLAGS(rsp_flags), .RSP_ERR(rsp_err),
      .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun),
      .ALU_ARITH_OUT(p1.ar), .ALU_LOGIC_OUT(p1.lg), .ALU_CMP_OUT(p1.cm),
      .ALU_SHIFT_OUT(p1.sh), .ALU_FLAGS(p1.fl)
   );

   // ---- DUT with ALU_LAT = 3 ----
   logic        d3_valid = 1'b0;
   logic        d3_ready, d3_r1_ready;
   logic        d3_r1_valid = 1'b0;
   logic [15:0] d3_a = '0, d3_b = '0, d3_r1_a = '0, d3_r1_b = '0;
   logic [3:0]  d3_fun = '0, d3_r1_fun = '0;
   logic        d3_rsp_valid, d3_rsp_id, d3_rsp_err;
   logic        d3_rsp_ready = 1'b1;
   logic [31:0] d3_rsp_data;
   logic [3:0]  d3_rsp_flags;
   logic [15:0] d3_alu_a, d3_alu_b;
   logic [3:0]  d3_alu_fun;
   alu_res_t    p3 [3];

   alu_req_arbiter #(.OP_WIDTH(16), .ALU_LAT(3)) dut3 (
      .CLK(clk), .RST(rst),
      .REQ0_VALID(d3_valid), .REQ0_READY(d3_ready),
      .REQ0_A(d3_a), .REQ0_B(d3_b), .REQ0_FUN(d3_fun),
      .REQ1_VALID(d3_r1_valid), .REQ1_READY(d3_r1_ready),
      .REQ1_A(d3_r1_a), .REQ1_B(d3_r1_b), .REQ1_FUN(d3_r1_fun),
      .RSP_VALID(d3_rsp_valid), .RSP_READY(d3_rsp_ready), .RSP_ID(d3_rsp_id),
      .RSP_DATA(d3_rsp_data), .RSP_FLAGS(d3_rsp_flags), .RSP_ERR(d3_rsp_err),
      .ALU_A(d3_alu_a), .ALU_B(d3_alu_b), .ALU_FUN(d3_alu_fun),
      .ALU_ARITH_OUT(p3[2].ar), .ALU_LOGIC_OUT(p3[2].lg), .ALU_CMP_OUT(p3[2].cm),
      .ALU_SHIFT_OUT(p3[2].sh), .ALU_FLAGS(p3[2].fl)
   );

   // Behavioural ALU_TOP: add/sub/mul/div, and/or/nand/nor, nop/eq/gt/lt, shifts
   function automatic alu_res_t alu_eval(input logic signed [15:0] a, input logic signed [15:0] b,
                                         input logic [3:0] f);
      alu_res_t r;
      logic signed [31:0] sa, sb;
      r  = '0;
      sa = a;
      sb = b;
      case (f[1:0])
         2'b00: r.ar = sa + sb;
         2'b01: r.ar = sa - sb;
         2'b10: r.ar = sa * sb;
         default: r.ar = (b != 0) ? sa / sb : 32'sd0;
      endcase
      case (f[1:0])
         2'b00: r.lg = a & b;
         2'b01: r.lg = a | b;
         2'b10: r.lg = ~(a & b);
         default: r.lg = ~(a | b);
      endcase
      case (f[1:0])
         2'b00: r.cm = 16'd0;
         2'b01: r.cm = (a == b) ? 16'd1 : 16'd0;
         2'b10: r.cm = (a > b)  ? 16'd2 : 16'd0;
         default: r.cm = (a < b) ? 16'd3 : 16'd0;
      endcase
      case (f[1:0])
         2'b00: r.sh = a >> 1;
         2'b01: r.sh = a << 1;
         2'b10: r.sh = a >>> 1;
         default: r.sh = a <<< 1;
      endcase
      r.fl = (f == 4'b1000) ? 4'b0000 : (4'b1000 >> f[3:2]);
      return r;
   endfunction

   always @(posedge clk) begin
      p1    <= alu_eval(alu_a, alu_b, alu_fun);
      p3[0] <= alu_eval(d3_alu_a, d3_alu_b, d3_alu_fun);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   exp_t sb[$];
   exp_t sb3[$];

   always @(negedge clk) begin : mon1
      exp_t e;
      #2;
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            check_eq("sb_unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check_eq("rsp_id",    32'(rsp_id),    32'(e.id));
            check_eq("rsp_data",  rsp_data,       e.data);
            check_eq("rsp_flags", 32'(rsp_flags), 32'(e.fl));
            check_eq("rsp_err",   32'(rsp_err),   32'(e.err));
         end
      end
   end

   always @(negedge clk) begin : mon3
      exp_t e;
      #2;
      if (!rst && d3_rsp_valid && d3_rsp_ready) begin
         if (sb3.size() == 0) begin
            check_eq("d3_unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = sb3.pop_front();
            check_eq("d3_rsp_id",    32'(d3_rsp_id),    32'(e.id));
            check_eq("d3_rsp_data",  d3_rsp_data,       e.data);
            check_eq("d3_rsp_flags", 32'(d3_rsp_flags), 32'(e.fl));
            check_eq("d3_rsp_err",   32'(d3_rsp_err),   32'(e.err));
         end
      end
   end

   // Present a command on port p, wait for the handshake, optionally expect a response
   task automatic send(input int p, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] f, input exp_t e, input bit push);
      int n = 0;
      req_a[p] = a;
      req_b[p] = b;
      req_fun[p] = f;
      req_valid[p] = 1'b1;
      #1;
      while (!req_ready[p] && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      if (!req_ready[p]) begin
         check_eq("req_ready_timeout", 32'd0, 32'd1);
         req_valid[p] = 1'b0;
      end else begin
         if (push) sb.push_back(e);
         @(negedge clk);
         req_valid[p] = 1'b0;
      end
   endtask

   // Count edges (accept edge = 1) until RSP_VALID is seen
   task automatic wait_rsp(output int edges);
      edges = 1;
      while (!rsp_valid && edges < 40) begin
         @(negedge clk); #1;
         edges++;
      end
      if (!rsp_valid) check_eq("rsp_valid_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n, p;
      bit seen;
      for (int i = 0; i < 2; i++) begin
         req_a[i] = '0; req_b[i] = '0; req_fun[i] = '0;
      end

      // Reset state, with both requesters already asking
      req_valid = 2'b11;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_rsp_data",  rsp_data,       32'd0);
      check_eq("rst_alu_fun",   32'(alu_fun),   32'h8);
      check_eq("rst_alu_a",     32'(alu_a),     32'd0);
      req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b0;

      // 1: lone add on port 0
      send(0, -16'sd10, -16'sd4, 4'b0000, exp_t'{1'b0, 32'hFFFF_FFF2, 4'b1000, 1'b0}, 1'b1);
      wait_rsp(lat);
      check_eq("t1_latency", 32'(lat), 32'd4);
      @(negedge clk);

      // 2: both requesters contend, pointer freshly reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req_a[0] = 16'd10; req_b[0] = -16'sd4; req_fun[0] = 4'b0010;
      req_a[1] = 16'd2;  req_b[1] = 16'd1;   req_fun[1] = 4'b0100;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         n = 0;
         while (req_ready == 2'b00 && n < 40) begin
            @(negedge clk); #1;
            n++;
         end
         if (req_ready == 2'b00) begin
            check_eq("t2_grant_timeout", 32'd0, 32'd1);
            break;
         end
         p = req_ready[1] ? 1 : 0;
         check_eq("t2_grant", 32'(p), 32'(k % 2));
         if (p == 0) sb.push_back(exp_t'{1'b0, 32'hFFFF_FFD8, 4'b1000, 1'b0});
         else        sb.push_back(exp_t'{1'b1, 32'h0000_0000, 4'b0100, 1'b0});
         @(negedge clk);
         wait_rsp(lat);
         @(negedge clk);
      end
      req_valid = 2'b00;

      // 3: divide by zero answered locally, then a real divide
      send(0, 16'd10, 16'd0, 4'b0011, exp_t'{1'b0, 32'd0, 4'b0000, 1'b1}, 1'b1);
      n = 0;
      while (!rsp_valid && n < 40) begin
         check_eq("t3_no_div_issue", 32'(alu_fun == 4'b0011), 32'd0);
         @(negedge clk); #1;
         n++;
      end
      check_eq("t3_err_rsp_seen", 32'(rsp_valid), 32'd1);
      check_eq("t3_no_div_issue", 32'(alu_fun == 4'b0011), 32'd0);
      @(negedge clk);
      send(0, 16'd10, 16'd5, 4'b0011, exp_t'{1'b0, 32'd2, 4'b1000, 1'b0}, 1'b1);
      wait_rsp(lat);
      @(negedge clk);

      // 4: compare with back-pressure, port 1 waiting meanwhile
      rsp_ready = 1'b0;
      send(0, 16'd2, 16'd1, 4'b1010, exp_t'{1'b0, 32'd2, 4'b0010, 1'b0}, 1'b1);
      req_a[1] = 16'd3; req_b[1] = 16'd1; req_fun[1] = 4'b0100;
      req_valid[1] = 1'b1;
      wait_rsp(lat);
      check_eq("t4_latency", 32'(lat), 32'd4);
      for (int c = 0; c < 5; c++) begin
         check_eq("t4_hold_valid", 32'(rsp_valid), 32'd1);
         check_eq("t4_hold_data",  rsp_data,       32'd2);
         check_eq("t4_hold_id",    32'(rsp_id),    32'd0);
         check_eq("t4_no_ready",   32'(req_ready), 32'd0);
         @(negedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      send(1, 16'd3, 16'd1, 4'b0100, exp_t'{1'b1, 32'd1, 4'b0100, 1'b0}, 1'b1);
      wait_rsp(lat);
      @(negedge clk);

      // 5: shift left, then reset while the next command is in WAIT
      send(1, 16'd1, 16'd0, 4'b1101, exp_t'{1'b1, 32'd2, 4'b0001, 1'b0}, 1'b1);
      wait_rsp(lat);
      @(negedge clk);
      send(0, 16'd7, 16'd1, 4'b0000, exp_t'{1'b0, 32'd8, 4'b1000, 1'b0}, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
      check_eq("t5_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("t5_rst_rsp_id",    32'(rsp_id),    32'd0);
      check_eq("t5_rst_rsp_data",  rsp_data,       32'd0);
      check_eq("t5_rst_rsp_flags", 32'(rsp_flags), 32'd0);
      check_eq("t5_rst_alu_fun",   32'(alu_fun),   32'h8);
      check_eq("t5_rst_alu_a",     32'(alu_a),     32'd0);
      check_eq("t5_rst_alu_b",     32'(alu_b),     32'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      check_eq("t5_dropped_no_rsp", 32'(seen), 32'd0);

      // 6: ALU_LAT = 3 instance
      d3_a = 16'd10; d3_b = 16'd4; d3_fun = 4'b0000; d3_valid = 1'b1;
      #1;
      n = 0;
      while (!d3_ready && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      check_eq("t6_accepted", 32'(d3_ready), 32'd1);
      sb3.push_back(exp_t'{1'b0, 32'd14, 4'b1000, 1'b0});
      @(negedge clk);
      d3_valid = 1'b0;
      lat = 1;
      while (!d3_rsp_valid && lat < 40) begin
         @(negedge clk); #1;
         lat++;
      end
      check_eq("t6_latency", 32'(lat), 32'd6);
      repeat (3) @(negedge clk);

      check_eq("sb_drained",  32'(sb.size()),  32'd0);
      check_eq("sb3_drained", 32'(sb3.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
